mux_seg7_scan: RTL and testbench

//  Parametrised successor of the 5-channel 3-bit select-to-7-segment path: CH_NUM channels of DATA_W bits, one

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decoder.sv | 33 +++
 rtl/mux_seg7_scan.sv | 124 ++++++++++++
 tb/tb_mux_seg7_scan.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment encodings and display-mode state for the multiplexed 7-segment scanner.
package seg7_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_state_e;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern; output polarity is the caller's concern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    // Hex digit lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_value)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            4'hF:    o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mux_seg7_scan.sv
// Channel mux + manual/scan FSM driving one registered 7-segment digit.
// Define SEG7_ACTIVE_LOW_EN to invert led7_out (including its reset value) for common-anode displays.
module mux_seg7_scan
    import seg7_pkg::*;
#(
    parameter int CH_NUM   = 5,
    parameter int DATA_W   = 3,
    parameter int SEL_W    = 3,
    parameter int PRESCALE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    output logic [6:0]               led7_out,
    output logic [SEL_W-1:0]         ch_out,
    output logic                     valid
);

    localparam int                CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0]  CH_LAST  = SEL_W'(CH_NUM - 1);
    localparam logic [SEL_W:0]    CH_LIMIT = (SEL_W + 1)'(CH_NUM);
`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0]        POL_MASK = 7'h7F;
`else
    localparam logic [6:0]        POL_MASK = 7'h00;
`endif

    mode_state_e       r_state;
    mode_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [SEL_W-1:0]  r_scan_ch;
    logic [SEL_W-1:0]  w_scan_ch_nxt;
    logic [SEL_W-1:0]  w_disp_ch;
    logic [DATA_W-1:0] w_ch_data;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg;
    logic              w_in_range;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, scan position and the channel to show on the coming edge
    always_comb begin
        w_state_nxt   = MANUAL;
        w_cnt_nxt     = '0;
        w_scan_ch_nxt = '0;
        w_disp_ch     = sel;
        if (mode) begin
            w_state_nxt = SCAN;
        end else begin
            w_state_nxt = MANUAL;
        end
        if (w_state_nxt == SCAN) begin
            // Entering scan restarts at channel 0 with a fresh prescale count
            if (r_state == SCAN) begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_scan_ch == CH_LAST) begin
                        w_scan_ch_nxt = '0;
                    end else begin
                        w_scan_ch_nxt = r_scan_ch + SEL_W'(1);
                    end
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_scan_ch_nxt = r_scan_ch;
                end
            end else begin
                w_cnt_nxt     = '0;
                w_scan_ch_nxt = '0;
            end
            w_disp_ch = w_scan_ch_nxt;
        end else begin
            w_disp_ch = sel;
        end
    end

    // Channel data mux; out-of-range selects read as zero
    always_comb begin
        w_ch_data = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_ch_data = (w_disp_ch == SEL_W'(k)) ? data_in[k*DATA_W +: DATA_W] : w_ch_data;
        end
        w_nibble   = 4'(w_ch_data);
        w_in_range = ({1'b0, w_disp_ch} < CH_LIMIT);
    end

    seg7_decoder u_decoder (
        .i_value (w_nibble),
        .o_seg   (w_seg)
    );

    // Scan counters and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_scan_ch <= '0;
            led7_out  <= SEG_BLANK ^ POL_MASK;
            ch_out    <= '0;
            valid     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_scan_ch <= w_scan_ch_nxt;
            ch_out    <= w_disp_ch;
            if (w_in_range) begin
                led7_out <= w_seg ^ POL_MASK;
                valid    <= 1'b1;
            end else begin
                led7_out <= SEG_BLANK ^ POL_MASK;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_seg7_scan.sv
// Directed self-checking bench for mux_seg7_scan (default parameters, either segment polarity).
module tb_mux_seg7_scan;

    logic        clk;
    logic        rst;
    logic [14:0] data_in;
    logic [2:0]  sel;
    logic        mode;
    logic [6:0]  led7_out;
    logic [2:0]  ch_out;
    logic        valid;

    int n_tests;
    int n_fail;

`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0] MASK = 7'h7F;
`else
    localparam logic [6:0] MASK = 7'h00;
`endif

    mux_seg7_scan #(
        .CH_NUM   (5),
        .DATA_W   (3),
        .SEL_W    (3),
        .PRESCALE (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .sel      (sel),
        .mode     (mode),
        .led7_out (led7_out),
        .ch_out   (ch_out),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int v);
        logic [6:0] s;
        case (v)
            0:       s = 7'h3F;
            1:       s = 7'h06;
            2:       s = 7'h5B;
            3:       s = 7'h4F;
            4:       s = 7'h66;
            5:       s = 7'h6D;
            6:       s = 7'h7D;
            7:       s = 7'h07;
            default: s = 7'h00;
        endcase
        return s ^ MASK;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        mode    = 1'b0;
        sel     = 3'd2;
        data_in = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

        tick();
        tick();
        check_eq("rst_led", 32'(led7_out), 32'(7'h00 ^ MASK));
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_ch", 32'(ch_out), 32'd0);

        rst = 1'b0;
        tick();
        check_eq("rel_ch", 32'(ch_out), 32'd2);
        check_eq("rel_led", 32'(led7_out), 32'(exp_seg(2)));
        check_eq("rel_valid", 32'(valid), 32'd1);

        sel = 3'd3;
        #2;
        check_eq("lat_hold", 32'(led7_out), 32'(exp_seg(2)));

        for (int s = 0; s < 5; s++) begin
            sel = 3'(s);
            tick();
            check_eq("man_led", 32'(led7_out), 32'(exp_seg(s)));
            check_eq("man_ch", 32'(ch_out), 32'(s));
            check_eq("man_valid", 32'(valid), 32'd1);
        end

        for (int s = 5; s < 8; s++) begin
            sel = 3'(s);
            tick();
            check_eq("oor_led", 32'(led7_out), 32'(7'h00 ^ MASK));
            check_eq("oor_ch", 32'(ch_out), 32'(s));
            check_eq("oor_valid", 32'(valid), 32'd0);
        end

        sel     = 3'd4;
        data_in = {3'd7, 3'd3, 3'd2, 3'd1, 3'd0};
        tick();
        check_eq("data_chg", 32'(led7_out), 32'(exp_seg(7)));
        data_in = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

        sel  = 3'd7;
        mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_eq("scan_ch", 32'(ch_out), 32'((i / 4) % 5));
            check_eq("scan_led", 32'(led7_out), 32'(exp_seg((i / 4) % 5)));
            check_eq("scan_valid", 32'(valid), 32'd1);
        end

        mode = 1'b0;
        sel  = 3'd1;
        tick();
        check_eq("leave_ch", 32'(ch_out), 32'd1);
        check_eq("leave_led", 32'(led7_out), 32'(exp_seg(1)));

        mode = 1'b1;
        tick();
        check_eq("entry_ch", 32'(ch_out), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        check_eq("mid_ch", 32'(ch_out), 32'd3);

        rst = 1'b1;
        tick();
        check_eq("mrst_led", 32'(led7_out), 32'(7'h00 ^ MASK));
        check_eq("mrst_ch", 32'(ch_out), 32'd0);
        check_eq("mrst_valid", 32'(valid), 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("restart_ch", 32'(ch_out), 32'(i / 4));
            check_eq("restart_valid", 32'(valid), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
